inst_prefetch: RTL and testbench
================================

INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 Parameter DEPTH, default 4, queue entries, power of two, minimum 2, and SHALL be honoured at that value.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset, and SHALL be honoured at that value.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 flush_i  in  1  redirect request from a taken branch or jump.
REQ-006 flush_pc_i  in  32  redirect target address.
REQ-007 stall_i  in  1  IF/ID cannot accept the head entry this cycle.
REQ-008 valid_o  out  1  head entry present on inst_o/pc_o.
REQ-009 inst_o  out  32  head instruction word.
REQ-010 pc_o  out  32  address of the head instruction.
REQ-011 mem_req_o  out  1  instruction memory read request, registered.
REQ-012 mem_addr_o  out  32  read address, registered, word-aligned.
REQ-013 mem_ack_i  in  1  memory returns data this cycle.
REQ-014 mem_rdata_i  in  32  read data, valid only when mem_ack_i=1.

Function
REQ-015 The block SHALL hold a FIFO of DEPTH {pc, inst} entries; valid_o=(count!=0); inst_o/pc_o SHALL be driven combinationally from the head entry.
REQ-016 Pop: valid_o=1 and stall_i=0 at a clock edge; push: mem_ack_i=1 in state REQ with no flush; a simultaneous push and pop SHALL leave count unchanged.
REQ-017 FSM states: IDLE, REQ, DISCARD; at most one memory request SHALL be outstanding.
REQ-018 IDLE->REQ when (count - pop_this_cycle) < DEPTH and flush_i=0; mem_req_o<=1 and mem_addr_o<=fetch_pc on that edge.
REQ-019 In REQ, mem_req_o and mem_addr_o SHALL stay constant until mem_ack_i=1.
REQ-020 REQ with ack: push {mem_addr_o, mem_rdata_i}; fetch_pc<=mem_addr_o+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0); stay in REQ with the next address if space remains after this push and pop, else drop mem_req_o and go to IDLE.
REQ-021 With a zero-wait memory (ack in every REQ cycle) and stall_i=0, throughput SHALL be one instruction per cycle.
REQ-022 Latency: an instruction acked at edge N SHALL be visible on valid_o/inst_o after edge N (next cycle), given no flush.
REQ-023 Full: count=DEPTH SHALL block any new request; data SHALL never be dropped for lack of space.
REQ-024 Empty: valid_o=0; stall_i SHALL be ignored.
REQ-025 Flush SHALL take priority over push and pop: the FIFO SHALL empty (valid_o=0 next cycle) and fetch_pc<={flush_pc_i[31:2],2'b00}.
REQ-026 Flush in REQ without ack SHALL deassert mem_req_o and enter DISCARD; DISCARD SHALL wait for mem_ack_i, drop that data, then enter IDLE.
REQ-027 Flush in REQ with ack in the same cycle SHALL drop the data and enter IDLE.
REQ-028 Flush in DISCARD SHALL update fetch_pc only and remain in DISCARD.
REQ-029 mem_ack_i in IDLE SHALL be ignored.
REQ-030 After a flush, the first request SHALL be for the flush target, and the earliest valid_o from it SHALL follow the rules in REQ-018 and REQ-022.

Reset
REQ-031 While rst=1 at an edge: count=0, state=IDLE, fetch_pc=RESET_PC, mem_req_o=0, mem_addr_o=0, valid_o=0.
REQ-032 A reset during REQ or DISCARD SHALL abandon the outstanding access; a later ack SHALL be ignored.
REQ-033 After rst deasserts, the first request SHALL use RESET_PC.

Verification
REQ-034 Reset release, zero-wait memory returning addr^32'hA5A5_0000, stall_i=0 -> mem_addr_o 0,4,8,... on consecutive cycles; pc_o/inst_o 0/A5A5_0000, 4/A5A5_0004, ... one per cycle.
REQ-035 stall_i=1 held, DEPTH=4 -> exactly 4 entries accepted, mem_req_o=0 afterwards, head pc_o=0 held; stall_i=0 -> pops resume in order 0,4,8,C, then fetch resumes at 0x10.
REQ-036 3-cycle ack latency, flush_i=1 with flush_pc_i=0x103 in the 2nd wait cycle -> ack data dropped, valid_o=0, next request address 0x100.
REQ-037 Flush in the same cycle as an ack and a pop, with count=2 -> valid_o=0 next cycle, no push, next request is the flush target.
REQ-038 Wrap: flush to 0xFFFF_FFFC -> entries pc_o FFFF_FFFC then 0000_0000.
REQ-039 rst=1 while in REQ, ack arrives 1 cycle after rst falls -> ack ignored; mem_req_o then asserts with mem_addr_o=RESET_PC.

Source files
------------

// File: rtl/inst_prefetch.sv
// inst_prefetch: instruction prefetch queue with a single-outstanding memory read FSM
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush_i, flush_pc_i      redirect: empty the queue and restart fetching at flush_pc_i (word-aligned)
//   stall_i                  consumer cannot take the head entry this cycle
//   valid_o, inst_o, pc_o    head entry of the queue
//   mem_req_o, mem_addr_o    registered read request and word address
//   mem_ack_i, mem_rdata_i   read data return
module inst_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        stall_i,
    output logic        valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_pc_mem   [DEPTH];
    logic [31:0]   r_inst_mem [DEPTH];

    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_cnt_after_pop;
    logic [31:0]   w_flush_pc;
    logic [31:0]   w_next_pc;

    assign valid_o         = r_count != '0;
    assign pc_o            = r_pc_mem[r_rd_ptr];
    assign inst_o          = r_inst_mem[r_rd_ptr];
    assign w_pop           = valid_o && !stall_i;
    assign w_push          = (r_state == REQ) && mem_ack_i && !flush_i;
    assign w_cnt_after_pop = r_count - CW'(w_pop);
    assign w_flush_pc      = flush_pc_i & ~32'h3;
    assign w_next_pc       = mem_addr_o + 32'd4;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]   <= mem_addr_o;
            r_inst_mem[r_wr_ptr] <= mem_rdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_fetch_pc <= RESET_PC;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
        end else begin
            if (flush_i) begin
                r_count    <= '0;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_fetch_pc <= w_flush_pc;
            end else begin
                r_count <= w_cnt_after_pop + CW'(w_push);
                if (w_pop)
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                if (w_push) begin
                    r_wr_ptr   <= r_wr_ptr + AW'(1);
                    r_fetch_pc <= w_next_pc;
                end
            end
            case (r_state)
                IDLE: begin
                    // a slot freed by this cycle's pop already counts as space
                    if (!flush_i && w_cnt_after_pop < CW'(DEPTH)) begin
                        r_state    <= REQ;
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= r_fetch_pc;
                    end
                end
                REQ: begin
                    if (flush_i) begin
                        mem_req_o <= 1'b0;
                        r_state   <= mem_ack_i ? IDLE : DISCARD;
                    end else if (mem_ack_i) begin
                        // keep streaming only if the queue still has room after this push
                        if (w_cnt_after_pop < CW'(DEPTH - 1)) begin
                            mem_addr_o <= w_next_pc;
                        end else begin
                            mem_req_o <= 1'b0;
                            r_state   <= IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (mem_ack_i)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inst_prefetch.sv
// tb_inst_prefetch: directed vector table plus randomized run against a queue-based reference model
module tb_inst_prefetch;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic [31:0] flush_pc_i = '0;
    logic        stall_i = 1'b0;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;

    inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .stall_i(stall_i), .valid_o(valid_o), .inst_o(inst_o), .pc_o(pc_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        r;
        logic        stall;
        logic        flush;
        logic [31:0] fpc;
        logic        ack;
        logic        ev;
        logic [31:0] epc;
        logic        ereq;
        logic [31:0] eaddr;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic r, input logic s, input logic f, input logic [31:0] fpc,
                       input logic a, input logic ev, input logic [31:0] epc,
                       input logic ereq, input logic [31:0] eaddr);
        vec_t v;
        v.r = r; v.stall = s; v.flush = f; v.fpc = fpc; v.ack = a;
        v.ev = ev; v.epc = epc; v.ereq = ereq; v.eaddr = eaddr;
        tv.push_back(v);
    endtask

    // reference model: queue of fetched entries plus the outstanding-request bookkeeping
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    bit          m_busy;
    bit          m_disc;
    bit          exp_req;
    logic [31:0] exp_addr;
    logic [31:0] m_fetch;

    task automatic model_edge(input logic r, input logic st, input logic fl, input logic [31:0] fp,
                              input logic ak, input logic [31:0] rd);
        bit   pop;
        ent_t e;
        if (r) begin
            q.delete();
            m_busy = 0; m_disc = 0; exp_req = 0; exp_addr = '0; m_fetch = RPC;
            return;
        end
        pop = q.size() != 0 && !st;
        if (fl) begin
            q.delete();
            m_fetch = fp & 32'hFFFF_FFFC;
        end else if (pop) begin
            void'(q.pop_front());
        end
        if (m_busy) begin
            if (fl) begin
                m_busy = 0; m_disc = !ak; exp_req = 0;
            end else if (ak) begin
                e.pc = exp_addr; e.inst = rd;
                q.push_back(e);
                m_fetch = exp_addr + 32'd4;
                if (q.size() < DEPTH) exp_addr = m_fetch;
                else begin m_busy = 0; exp_req = 0; end
            end
        end else if (m_disc) begin
            if (ak) m_disc = 0;
        end else if (!fl && q.size() < DEPTH) begin
            m_busy = 1; exp_req = 1; exp_addr = m_fetch;
        end
    endtask

    task automatic check_model();
        chk("rand valid", {31'b0, valid_o}, {31'b0, q.size() != 0});
        if (q.size() != 0) begin
            chk("rand pc", pc_o, q[0].pc);
            chk("rand inst", inst_o, q[0].inst);
        end
        chk("rand req", {31'b0, mem_req_o}, {31'b0, exp_req});
        if (exp_req) chk("rand addr", mem_addr_o, exp_addr);
    endtask

    bit mem_pending = 0;
    int mem_wait = 0;
    bit burst = 0;

    initial begin
        add(1,0,0,0,0,            0,0,0,0);
        add(0,0,0,0,0,            0,0,1,0);
        add(0,0,0,0,1,            1,0,1,4);
        add(0,0,0,0,1,            1,4,1,8);
        add(0,0,0,0,1,            1,8,1,'hC);
        add(0,0,0,0,1,            1,'hC,1,'h10);
        add(1,0,0,0,0,            0,0,0,0);
        add(0,0,0,0,1,            0,0,1,0);
        add(0,1,0,0,1,            1,0,1,4);
        add(0,1,0,0,1,            1,0,1,8);
        add(0,1,0,0,1,            1,0,1,'hC);
        add(0,1,0,0,1,            1,0,0,0);
        add(0,1,0,0,1,            1,0,0,0);
        add(0,1,0,0,0,            1,0,0,0);
        add(0,0,0,0,0,            1,4,1,'h10);
        add(0,0,0,0,0,            1,8,1,'h10);
        add(0,0,0,0,0,            1,'hC,1,'h10);
        add(0,0,0,0,1,            1,'h10,1,'h14);
        add(0,0,0,0,0,            0,0,1,'h14);
        add(0,0,1,'h103,0,        0,0,0,0);
        add(0,0,0,0,1,            0,0,0,0);
        add(0,0,0,0,0,            0,0,1,'h100);
        add(0,0,0,0,1,            1,'h100,1,'h104);
        add(0,1,0,0,1,            1,'h100,1,'h108);
        add(0,0,1,'h200,1,        0,0,0,0);
        add(0,0,0,0,0,            0,0,1,'h200);
        add(0,0,1,'hFFFF_FFFC,0,  0,0,0,0);
        add(0,0,0,0,1,            0,0,0,0);
        add(0,0,0,0,0,            0,0,1,'hFFFF_FFFC);
        add(0,0,0,0,1,            1,'hFFFF_FFFC,1,0);
        add(0,0,0,0,1,            1,0,1,4);
        add(0,0,1,'h300,0,        0,0,0,0);
        add(0,0,1,'h400,0,        0,0,0,0);
        add(0,0,0,0,1,            0,0,0,0);
        add(0,0,0,0,0,            0,0,1,'h400);

        @(negedge clk);
        for (int i = 0; i < tv.size(); i++) begin
            rst = tv[i].r;
            stall_i = tv[i].stall;
            flush_i = tv[i].flush;
            flush_pc_i = tv[i].fpc;
            mem_ack_i = tv[i].ack;
            mem_rdata_i = mem_addr_o ^ 32'hA5A5_0000;
            @(negedge clk);
            chk($sformatf("step%0d valid", i), {31'b0, valid_o}, {31'b0, tv[i].ev});
            if (tv[i].ev) begin
                chk($sformatf("step%0d pc", i), pc_o, tv[i].epc);
                chk($sformatf("step%0d inst", i), inst_o, tv[i].epc ^ 32'hA5A5_0000);
            end
            chk($sformatf("step%0d req", i), {31'b0, mem_req_o}, {31'b0, tv[i].ereq});
            if (tv[i].ereq) chk($sformatf("step%0d addr", i), mem_addr_o, tv[i].eaddr);
        end

        rst = 1; stall_i = 0; flush_i = 0; mem_ack_i = 0;
        @(posedge clk);
        model_edge(1, 0, 0, 0, 0, 0);
        mem_pending = 0;
        @(negedge clk);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check_model();
            if (cyc % 250 == 0) burst = !burst;
            rst = $urandom_range(299) == 0;
            stall_i = burst ? 1'b0 : ($urandom_range(9) < 3);
            flush_i = burst ? ($urandom_range(99) == 0) : ($urandom_range(19) == 0);
            flush_pc_i = $urandom;
            if (!mem_pending && mem_req_o) begin
                mem_pending = 1;
                mem_wait = burst ? 0 : int'($urandom_range(3));
            end
            mem_ack_i = mem_pending ? (mem_wait == 0) : ($urandom_range(9) == 0);
            mem_rdata_i = $urandom;
            @(posedge clk);
            model_edge(rst, stall_i, flush_i, flush_pc_i, mem_ack_i, mem_rdata_i);
            if (mem_pending) begin
                if (mem_ack_i) mem_pending = 0;
                else mem_wait--;
            end
            @(negedge clk);
        end
        check_model();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
